pipe_stage_buf: RTL and testbench

Parametrised inter-stage pipeline buffer for the processor pipeline: successor to the fixed-field stage latches (fetch/decode, decode/execute, …). It carries an opaque WIDTH-bit payload (control bits, operands, instruction word packed by the caller) through a 2-entry skid buffer with valid/ready handshake, so a downstream stall never drops data and never creates a combinational ready path upstream. It also provides flush with a programmable squash count for branch and interrupt recovery, and drives a defined bubble payload whenever empty.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_squash_ctr.sv | 28 ++
 rtl/pipe_stage_buf.sv | 79 +++++++
 tb/tb_pipe_stage_buf.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: payload defaults,
// counter width default and the occupancy encoding.
package pipe_pkg;
  localparam int unsigned DEF_WIDTH   = 64;
  localparam int unsigned DEF_FLUSH_W = 2;

  // All-zero word decodes as a NOP in every stage, so it doubles as the bubble.
  localparam logic [DEF_WIDTH-1:0] NOP_PAYLOAD    = '0;
  localparam logic [DEF_WIDTH-1:0] BUBBLE_PAYLOAD = NOP_PAYLOAD;

  typedef logic [1:0] occ_t;

  function automatic occ_t occ_count(input logic head_v, input logic skid_v);
    return occ_t'({1'b0, head_v}) + occ_t'({1'b0, skid_v});
  endfunction
endpackage

// File: rtl/pipe_squash_ctr.sv
// Load / decrement-to-zero counter that drops the first N inputs after a flush.
module pipe_squash_ctr
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_W = DEF_FLUSH_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [FLUSH_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               squashing_o
);
  logic [FLUSH_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - FLUSH_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign squashing_o = (cnt_q != '0);
endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages with flush/squash recovery.
// InReady is a pure function of registered state, so no ready path crosses it.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH   = DEF_WIDTH,
  parameter int unsigned       FLUSH_W = DEF_FLUSH_W,
  parameter logic [WIDTH-1:0]  BUBBLE  = '0
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   InData,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   OutData,
  input  logic               Flush,
  input  logic [FLUSH_W-1:0] FlushCount,
  output logic               Squashing,
  output occ_t               Occupancy
);
  logic             head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic             accept, drain, store;

  assign InReady = !skid_v_q;
  assign accept  = InValid && InReady;
  assign drain   = head_v_q && OutReady;
  // Flush-cycle inputs and squashed inputs are consumed but never stored.
  assign store   = accept && !Squashing && !Flush;

  always_comb begin
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    head_d   = head_q;
    skid_d   = skid_q;
    if (Flush) begin
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (drain && skid_v_q) begin
      head_d   = skid_q;
      skid_v_d = 1'b0;
    end else if (drain || !head_v_q) begin
      head_v_d = store;
      if (store) head_d = InData;
    end else if (store) begin
      skid_v_d = 1'b1;
      skid_d   = InData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      head_q   <= BUBBLE;
      skid_q   <= BUBBLE;
    end else begin
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
    end
  end

  pipe_squash_ctr #(.FLUSH_W(FLUSH_W)) u_squash (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .load_i      (Flush),
    .load_val_i  (FlushCount),
    .dec_i       (accept),
    .squashing_o (Squashing)
  );

  assign OutValid  = head_v_q;
  assign OutData   = head_v_q ? head_q : BUBBLE;
  assign Occupancy = occ_count(head_v_q, skid_v_q);
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: vector table plus a stall-hold sequence.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned FW = 2;
  localparam logic [W-1:0] BUB = 8'hEE;

  logic          Clk = 1'b0;
  logic          Rst, InValid, InReady, OutValid, OutReady, Flush, Squashing;
  logic [W-1:0]  InData, OutData;
  logic [FW-1:0] FlushCount;
  occ_t          Occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_buf #(.WIDTH(W), .FLUSH_W(FW), .BUBBLE(BUB)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .InData(InData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Flush(Flush), .FlushCount(FlushCount), .Squashing(Squashing), .Occupancy(Occupancy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          rst, iv;
    logic [W-1:0]  id;
    logic          ordy, fl;
    logic [FW-1:0] fc;
    logic          ov;
    logic [W-1:0]  od;
    logic          ir;
    logic [1:0]    occ;
    logic          sq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic iv, logic [W-1:0] id, logic ordy, logic fl,
                              logic [FW-1:0] fc, logic ov, logic [W-1:0] od, logic ir,
                              logic [1:0] occ, logic sq);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.fc = fc;
    v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.sq = sq;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic fl, input logic [FW-1:0] fc);
    Rst = rst; InValid = iv; InData = id; OutReady = ordy; Flush = fl; FlushCount = fc;
  endtask

  initial begin
    drive(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, '0);

    // rst iv id ordy fl fc | ov od ir occ sq  (outputs after the edge)
    add(1, 1, 8'hAA, 1, 0, 0,   0, BUB, 1, 0, 0);
    add(1, 1, 8'hAA, 1, 1, 3,   0, BUB, 1, 0, 0);   // reset beats flush
    for (int k = 1; k <= 8; k++)
      add(0, 1, W'(k), 1, 0, 0, 1, W'(k), 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,   0, BUB, 1, 0, 0);
    // stall / skid
    add(0, 1, 8'h11, 0, 0, 0,   1, 8'h11, 1, 1, 0);
    add(0, 1, 8'h22, 0, 0, 0,   1, 8'h11, 0, 2, 0);
    add(0, 1, 8'h33, 0, 0, 0,   1, 8'h11, 0, 2, 0);
    add(0, 1, 8'h33, 1, 0, 0,   1, 8'h22, 1, 1, 0);
    add(0, 1, 8'h33, 1, 0, 0,   1, 8'h33, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,   0, BUB, 1, 0, 0);
    // flush with squash from full
    add(0, 1, 8'hA1, 0, 0, 0,   1, 8'hA1, 1, 1, 0);
    add(0, 1, 8'hA2, 0, 0, 0,   1, 8'hA1, 0, 2, 0);
    add(0, 1, 8'h44, 0, 1, 2,   0, BUB, 1, 0, 1);
    add(0, 1, 8'h55, 1, 0, 0,   0, BUB, 1, 0, 1);
    add(0, 1, 8'h66, 1, 0, 0,   0, BUB, 1, 0, 0);
    add(0, 1, 8'h77, 1, 0, 0,   1, 8'h77, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,   0, BUB, 1, 0, 0);
    // flush during drain, count 0
    add(0, 1, 8'h5A, 0, 0, 0,   1, 8'h5A, 1, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0,   0, BUB, 1, 0, 0);
    add(0, 1, 8'h5B, 1, 0, 0,   1, 8'h5B, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,   0, BUB, 1, 0, 0);
    // same-cycle accept on flush is dropped without decrementing
    add(0, 1, 8'hC1, 1, 1, 1,   0, BUB, 1, 0, 1);
    add(0, 1, 8'hC2, 1, 0, 0,   0, BUB, 1, 0, 0);
    add(0, 1, 8'hC3, 1, 0, 0,   1, 8'hC3, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,   0, BUB, 1, 0, 0);
    // reset during squash
    add(0, 0, 8'h00, 1, 1, 3,   0, BUB, 1, 0, 1);
    add(0, 1, 8'hD1, 1, 0, 0,   0, BUB, 1, 0, 1);
    add(1, 1, 8'hD2, 1, 0, 0,   0, BUB, 1, 0, 0);
    add(0, 1, 8'hD3, 1, 0, 0,   1, 8'hD3, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0,   0, BUB, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].fc);
      @(posedge Clk); #1;
      chk("OutValid",  i, W'(OutValid),  W'(vecs[i].ov));
      chk("OutData",   i, OutData,       vecs[i].od);
      chk("InReady",   i, W'(InReady),   W'(vecs[i].ir));
      chk("Occupancy", i, W'(Occupancy), W'(vecs[i].occ));
      chk("Squashing", i, W'(Squashing), W'(vecs[i].sq));
    end

    // Hold a full buffer under stall: payload must not move, then drain in order.
    drive(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0, '0);
    @(posedge Clk); #1;
    InData = 8'hE2;
    @(posedge Clk); #1;
    InData = 8'hE3;
    for (int c = 0; c < 4; c++) begin
      @(posedge Clk); #1;
      chk("hold_data",  100 + c, OutData,       8'hE1);
      chk("hold_ready", 100 + c, W'(InReady),   W'(1'b0));
      chk("hold_occ",   100 + c, W'(Occupancy), W'(2'd2));
    end
    InValid = 1'b0; OutReady = 1'b1;
    chk("drain_head", 110, OutData, 8'hE1);
    @(posedge Clk); #1;
    chk("drain_skid", 111, OutData, 8'hE2);
    chk("drain_rdy",  111, W'(InReady), W'(1'b1));
    @(posedge Clk); #1;
    chk("drain_empty", 112, W'(OutValid), W'(1'b0));
    chk("drain_bub",   112, OutData, BUB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
